alu_sequencer: RTL and testbench

Multi-cycle operand sequencer that sits directly upstream of the 8-bit ALU (add / subtract / pass-through of `b`). It accepts one 16-bit instruction at a time over a valid/ready handshake and holds a 4×8-bit register file. It reads the operands, drives the ALU's `a`, `b` and `op` inputs, captures the ALU's combinational `result`, and writes it back to the destination register. The ALU stays a separate instance; this block only feeds and consumes it.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/alu.sv | 23 ++
 rtl/regfile_4x8.sv | 36 +++
 rtl/alu_sequencer.sv | 122 ++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the ALU operand sequencer: op codes, instruction
// field positions and the sequencer state encoding.
package cpu_pkg;

  // Op codes double as the ALU mux select.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;

  // Instruction field bit positions.
  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 11;
  localparam int RS_MSB      = 10;
  localparam int RS_LSB      = 9;
  localparam int IMM_SEL_BIT = 8;
  localparam int IMM_MSB     = 7;
  localparam int IMM_LSB     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Anything above MOV has no writeback.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational ALU fed by the sequencer: add, subtract, pass b.
module alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] result
);
  import cpu_pkg::*;

  // Result select; unsupported codes produce zero.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MOV:  result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_4x8.sv
// Small register file: one write port, three combinational read ports
// (destination operand, source operand, debug).
module regfile_4x8 #(
  parameter int NREGS = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic [AW-1:0] rs_addr,
  output logic [W-1:0]  rs_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] regs [NREGS];

  // Storage with synchronous clear; a write is visible to readers the cycle after its edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd_data  = regs[rd_addr];
  assign rs_data  = regs[rs_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle operand sequencer in front of the 8-bit ALU.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an instruction
//   READ  | operands read from the register file into the ALU input regs
//   EXEC  | ALU inputs stable, result captured into res_q
//   WB    | legal ops write res_q to rd and update zero; done pulses next
module alu_sequencer #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_instr,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  output logic         done,
  output logic         illegal,
  output logic         zero,
  input  logic [1:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);
  import cpu_pkg::*;

  localparam int AW = $clog2(NREGS);

  state_t        state, state_nx;
  logic [15:0]   instr_q;
  logic [W-1:0]  res_q;
  logic          we;

  logic [2:0]    op_f;
  logic [AW-1:0] rd_f;
  logic [AW-1:0] rs_f;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  src;

  assign op_f = instr_q[OP_MSB:OP_LSB];
  assign rd_f = instr_q[RD_MSB:RD_LSB];
  assign rs_f = instr_q[RS_MSB:RS_LSB];
  assign src  = instr_q[IMM_SEL_BIT] ? instr_q[IMM_MSB:IMM_LSB] : rs_data;

  regfile_4x8 #(
    .NREGS (NREGS),
    .W     (W),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (rd_f),
    .wdata    (res_q),
    .rd_addr  (rd_f),
    .rd_data  (rd_data),
    .rs_addr  (rs_f),
    .rs_data  (rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state, handshake ready and writeback enable.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    we       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_READ;
      end
      ST_READ: state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        we       = op_is_legal(op_f);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: the ALU input registers serve as the operand latches, so the
  // ALU sees them from the READ->EXEC edge and they hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      res_q   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state == ST_IDLE && in_valid) instr_q <= in_instr;
      if (state == ST_READ) begin
        alu_a  <= rd_data;
        alu_b  <= src;
        alu_op <= op_f;
      end
      if (state == ST_EXEC) res_q <= alu_result;
      if (state == ST_WB) begin
        done    <= 1'b1;
        illegal <= !op_is_legal(op_f);
        if (op_is_legal(op_f)) zero <= (res_q == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with the real ALU attached; directed scenarios
// plus random instructions checked against an architectural model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        done, illegal, zero;
  logic [1:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_regs [4];
  logic       m_zero;

  always #10 clk = ~clk;

  alu_sequencer #(.NREGS(4), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .done       (done),
    .illegal    (illegal),
    .zero       (zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  alu #(.W(8)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs,
                                     input int sel, input int imm);
    logic [15:0] v;
    v = {op[2:0], rd[1:0], rs[1:0], sel[0], imm[7:0]};
    return v;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check_val($sformatf("%s r%0d", tag, i), 16'(dbg_data), 16'(m_regs[i]));
    end
  endtask

  task automatic model_clear;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
    m_zero = 1'b0;
  endtask

  task automatic wait_ready;
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check_val("ready timeout", 16'(in_ready), 16'd1);
  endtask

  // Called just after the acceptance edge; follows one instruction to retirement.
  task automatic finish_instr(input logic [15:0] ins, output int low_cycles);
    int         op, rd, rs, lat, sum;
    logic [7:0] src, res;
    logic       legal;
    op    = int'(ins[15:13]);
    rd    = int'(ins[12:11]);
    rs    = int'(ins[10:9]);
    src   = ins[8] ? ins[7:0] : m_regs[rs];
    legal = (op <= 2);
    if (op == 0)      sum = (int'(m_regs[rd]) + int'(src)) % 256;
    else if (op == 1) sum = (int'(m_regs[rd]) + 256 - int'(src)) % 256;
    else              sum = int'(src);
    res = 8'(sum);
    low_cycles = 0;
    if (!in_ready) low_cycles++;
    check_val("in_ready drop", 16'(in_ready), 16'd0);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        check_val("alu_a", 16'(alu_a), 16'(m_regs[rd]));
        check_val("alu_b", 16'(alu_b), 16'(src));
        check_val("alu_op", 16'(alu_op), 16'(op));
      end
      if (done) begin
        lat = k;
        break;
      end
      if (!in_ready) low_cycles++;
    end
    check_val("latency", 16'(lat), 16'd3);
    check_val("illegal", 16'(illegal), 16'(!legal));
    check_val("ready after done", 16'(in_ready), 16'd1);
    if (legal) begin
      m_regs[rd] = res;
      m_zero     = (res == 8'd0);
    end
    check_val("zero", 16'(zero), 16'(m_zero));
    check_regs("wb");
  endtask

  task automatic run_instr(input logic [15:0] ins);
    int lc;
    wait_ready;
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_instr(ins, lc);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lc;
    bit          seen;
    logic [15:0] a_ins, b_ins, r_ins;

    do_reset;
    check_val("rst in_ready", 16'(in_ready), 16'd1);
    check_val("rst done", 16'(done), 16'd0);
    check_val("rst illegal", 16'(illegal), 16'd0);
    check_val("rst zero", 16'(zero), 16'd0);
    check_val("rst alu_a", 16'(alu_a), 16'd0);
    check_val("rst alu_b", 16'(alu_b), 16'd0);
    check_val("rst alu_op", 16'(alu_op), 16'd0);
    check_regs("rst");

    // MOV r0,#5
    run_instr(16'h4105);
    dbg_addr = 2'd0; #1;
    check_val("mov r0", 16'(dbg_data), 16'd5);

    // r1 = 9; ADD r0,r1 -> 14; SUB r0,#14 -> 0
    run_instr(mk(2, 1, 0, 1, 9));
    run_instr(mk(0, 0, 1, 0, 0));
    dbg_addr = 2'd0; #1;
    check_val("add r0", 16'(dbg_data), 16'd14);
    run_instr(mk(1, 0, 0, 1, 14));
    check_val("sub zero", 16'(zero), 16'd1);

    // Wrap-around both ways
    run_instr(mk(2, 2, 0, 1, 255));
    run_instr(mk(0, 2, 0, 1, 1));
    dbg_addr = 2'd2; #1;
    check_val("wrap add r2", 16'(dbg_data), 16'd0);
    check_val("wrap add zero", 16'(zero), 16'd1);
    run_instr(mk(2, 3, 0, 1, 0));
    run_instr(mk(1, 3, 0, 1, 1));
    dbg_addr = 2'd3; #1;
    check_val("wrap sub r3", 16'(dbg_data), 16'd255);
    check_val("wrap sub zero", 16'(zero), 16'd0);

    // rd == rs uses the old value
    run_instr(mk(2, 1, 0, 1, 8'h21));
    run_instr(mk(0, 1, 1, 0, 0));
    dbg_addr = 2'd1; #1;
    check_val("rd eq rs", 16'(dbg_data), 16'h42);

    // Two queued instructions with in_valid held high
    a_ins = mk(2, 1, 0, 1, 8'h33);
    b_ins = mk(0, 1, 1, 0, 0);
    wait_ready;
    in_valid = 1'b1;
    in_instr = a_ins;
    @(posedge clk); #1;
    in_instr = b_ins;
    finish_instr(a_ins, lc);
    check_val("busy cycles", 16'(lc), 16'd3);
    dbg_addr = 2'd1; #1;
    check_val("queued not early", 16'(dbg_data), 16'h33);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("done one cycle", 16'(done), 16'd0);
    finish_instr(b_ins, lc);
    dbg_addr = 2'd1; #1;
    check_val("queued result", 16'(dbg_data), 16'h66);

    // Illegal op 5
    run_instr(16'hA1FF);

    // Random instructions against the model
    for (int n = 0; n < 40; n++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
      r_ins = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      run_instr(r_ins);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset while in EXEC
    run_instr(mk(2, 3, 0, 1, 8'hC3));
    wait_ready;
    in_valid = 1'b1;
    in_instr = mk(2, 0, 0, 1, 8'h5A);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear;
    check_val("rst exec done", 16'(done), 16'd0);
    check_val("rst exec ready", 16'(in_ready), 16'd1);
    check_val("rst exec zero", 16'(zero), 16'd0);
    check_regs("rst exec");
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check_val("no done after rst", 16'(seen), 16'd0);
    run_instr(mk(2, 1, 0, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
